// File: rtl/jtag_stream_ctrl_if.sv
// Byte stream and solver readback bundle between the JTAG controller and the downstream solver.
// The controller side (master) sources the inbound byte stream and consumes the result word.
interface jtag_stream_ctrl_if #(
    parameter int RESULT_WIDTH = 16
) ();

    logic [7:0]              in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [RESULT_WIDTH-1:0] result_data;
    logic                    result_valid;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  result_data,
        input  result_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output result_data,
        output result_valid
    );

endinterface

// File: rtl/jtag_stream_ctrl.sv
// BSCAN USER-register bridge: 8-bit DR scans push bytes into an inbound FIFO,
// longer scans read back the solver result LSB first on tdo.
module jtag_stream_ctrl #(
    parameter int FIFO_DEPTH   = 16,
    parameter int RESULT_WIDTH = 16
) (
    input  logic tck,
    input  logic rst_n,
    input  logic test_logic_reset,
    input  logic ir_is_user,
    input  logic capture_dr,
    input  logic shift_dr,
    input  logic update_dr,
    input  logic tdi,
    output logic tdo,
    output logic end_of_input,
    output logic overflow,
    jtag_stream_ctrl_if.master stream
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        SHIFT,
        UPDATE
    } scan_state_t;

    scan_state_t             state;
    logic [4:0]              bit_cnt;
    logic [7:0]              in_shift;
    logic [RESULT_WIDTH-1:0] out_shift;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             eof_flag;
    logic             last_was_nl;

    logic in_scan;
    logic do_capture;
    logic do_shift;
    logic push_req;
    logic push_ok;
    logic pop;
    logic fifo_empty;
    logic fifo_full;

    // Shifts only count inside a scan that began with a capture, so a scan
    // interrupted by reset cannot reach a count of 8 and push a partial byte.
    assign in_scan    = (state == CAPTURE) || (state == SHIFT);
    assign do_capture = ir_is_user && capture_dr;
    assign do_shift   = ir_is_user && shift_dr && !capture_dr && in_scan;
    assign push_req   = ir_is_user && update_dr && in_scan && (bit_cnt == 5'd8);

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                        (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

    assign pop     = !fifo_empty && stream.in_ready;
    assign push_ok = push_req && (!fifo_full || pop) && !test_logic_reset;

    assign stream.in_valid = !fifo_empty;
    assign stream.in_data  = fifo_empty ? 8'h00 : mem[rd_ptr[ADDR_W-1:0]];
    assign end_of_input    = eof_flag && fifo_empty;
    assign tdo             = ir_is_user ? out_shift[0] : 1'b0;

    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            in_shift  <= '0;
            out_shift <= '0;
        end else if (test_logic_reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            in_shift  <= '0;
            out_shift <= '0;
        end else begin
            if (!ir_is_user) begin
                state <= IDLE;
            end else if (update_dr) begin
                state <= UPDATE;
            end else if (capture_dr) begin
                state <= CAPTURE;
            end else begin
                case (state)
                    IDLE:    state <= IDLE;
                    CAPTURE: state <= shift_dr ? SHIFT : CAPTURE;
                    SHIFT:   state <= SHIFT;
                    UPDATE:  state <= IDLE;
                    default: state <= IDLE;
                endcase
            end

            if (do_capture) begin
                bit_cnt   <= '0;
                out_shift <= stream.result_valid ? stream.result_data : '0;
            end else if (do_shift) begin
                bit_cnt   <= (bit_cnt == 5'd31) ? bit_cnt : bit_cnt + 5'd1;
                in_shift  <= {tdi, in_shift[7:1]};
                out_shift <= out_shift >> 1;
            end
        end
    end

    always_ff @(posedge tck) begin
        if (push_ok) begin
            mem[wr_ptr[ADDR_W-1:0]] <= in_shift;
        end
    end

    // The terminator is two consecutive accepted newlines; dropped bytes do not break the pair.
    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            eof_flag    <= 1'b0;
            last_was_nl <= 1'b0;
            overflow    <= 1'b0;
        end else if (test_logic_reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            eof_flag    <= 1'b0;
            last_was_nl <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr      <= wr_ptr + 1'b1;
                last_was_nl <= (in_shift == 8'h0A);
                if (last_was_nl && (in_shift == 8'h0A)) begin
                    eof_flag <= 1'b1;
                end
            end else if (push_req) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule
